// File: rtl/arc_plotter_if.sv
// Pixel bus between an arc engine and the shared VGA adapter.
// The master drives the pixel and its valid flag; the slave answers with ready.
interface arc_plotter_if #(
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int CW = 3
) ();
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CW-1:0] vga_colour;
    logic          vga_plot;
    logic          vga_ready;

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot,
        input  vga_ready
    );

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot,
        output vga_ready
    );
endinterface

// File: rtl/arc_plotter.sv
// Midpoint-circle arc engine with octant masking, clipping, optional pre-clear
// sweep and ready/plot backpressure on the VGA pixel bus.
module arc_plotter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          done,
    input  logic [XW-1:0] centre_x,
    input  logic [YW-1:0] centre_y,
    input  logic [XW-1:0] radius,
    input  logic [CW-1:0] colour,
    input  logic [7:0]    octant_mask,
    input  logic          clear_first,
    arc_plotter_if.master vga
);
    localparam int PW  = ((XW > YW) ? XW : YW) + 2;
    localparam int CRW = XW + 3;

    typedef logic signed [PW-1:0]  coord_t;
    typedef logic signed [CRW-1:0] crit_t;

    localparam coord_t        X_LIM  = coord_t'(SCREEN_W);
    localparam coord_t        Y_LIM  = coord_t'(SCREEN_H);
    localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_INIT, S_PLOT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    slot_q, slot_d;
    coord_t        ox_q, ox_d, oy_q, oy_d;
    crit_t         crit_q, crit_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic [CW-1:0] col_q, col_d;
    logic [7:0]    mask_q, mask_d;
    logic [XW-1:0] clr_x_q, clr_x_d;
    logic [YW-1:0] clr_y_q, clr_y_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [CW-1:0] c_q, c_d;
    logic          plot_q, plot_d;
    logic          done_q, done_d;

    logic   stall;
    coord_t oy_inc, ox_dec, cxs, cys, px, py;
    logic   live;

    assign stall  = plot_q & ~vga.vga_ready;
    assign oy_inc = oy_q + coord_t'(1);
    assign ox_dec = ox_q - coord_t'(1);

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        crit_d  = crit_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        col_d   = col_q;
        mask_d  = mask_q;
        clr_x_d = clr_x_q;
        clr_y_d = clr_y_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cx_d    = centre_x;
                    cy_d    = centre_y;
                    col_d   = colour;
                    mask_d  = octant_mask;
                    ox_d    = coord_t'(radius);
                    oy_d    = '0;
                    crit_d  = crit_t'(1) - crit_t'(radius);
                    clr_x_d = '0;
                    clr_y_d = '0;
                    state_d = clear_first ? S_CLEAR : S_INIT;
                end
            end
            S_CLEAR: begin
                if (!stall) begin
                    if (clr_y_q == Y_LAST) begin
                        clr_y_d = '0;
                        if (clr_x_q == X_LAST) state_d = S_INIT;
                        else                   clr_x_d = clr_x_q + 1'b1;
                    end else begin
                        clr_y_d = clr_y_q + 1'b1;
                    end
                end
            end
            S_INIT: begin
                slot_d  = '0;
                state_d = S_PLOT;
            end
            S_PLOT: begin
                if (!stall) begin
                    if (slot_q == 3'd7) begin
                        // Exit test uses the post-update ox/oy.
                        oy_d   = oy_inc;
                        slot_d = '0;
                        if (crit_q[CRW-1] || crit_q == '0) begin
                            crit_d = crit_q + crit_t'(2 * int'(oy_inc) + 1);
                            if (oy_inc > ox_q) state_d = S_DONE;
                        end else begin
                            ox_d   = ox_dec;
                            crit_d = crit_q + crit_t'(2 * (int'(oy_inc) - int'(ox_dec)) + 1);
                            if (oy_inc > ox_dec) state_d = S_DONE;
                        end
                    end else begin
                        slot_d = slot_q + 3'd1;
                    end
                end
            end
            S_DONE: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register in step with it.
    always_comb begin
        cxs = coord_t'(cx_d);
        cys = coord_t'(cy_d);
        px  = cxs;
        py  = cys;
        unique case (slot_d)
            3'd0: begin px = cxs + ox_d; py = cys + oy_d; end
            3'd1: begin px = cxs + oy_d; py = cys + ox_d; end
            3'd2: begin px = cxs - oy_d; py = cys + ox_d; end
            3'd3: begin px = cxs - ox_d; py = cys + oy_d; end
            3'd4: begin px = cxs - ox_d; py = cys - oy_d; end
            3'd5: begin px = cxs - oy_d; py = cys - ox_d; end
            3'd6: begin px = cxs + oy_d; py = cys - ox_d; end
            default: begin px = cxs + ox_d; py = cys - oy_d; end
        endcase
        live = mask_d[slot_d] && !px[PW-1] && (px < X_LIM) && !py[PW-1] && (py < Y_LIM);

        x_d    = x_q;
        y_d    = y_q;
        c_d    = c_q;
        plot_d = 1'b0;
        done_d = (state_d == S_DONE);
        if (state_d == S_CLEAR) begin
            plot_d = 1'b1;
            x_d    = clr_x_d;
            y_d    = clr_y_d;
            c_d    = '0;
        end else if (state_d == S_PLOT) begin
            plot_d = live;
            x_d    = px[XW-1:0];
            y_d    = py[YW-1:0];
            c_d    = col_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            crit_q  <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            col_q   <= '0;
            mask_q  <= '0;
            clr_x_q <= '0;
            clr_y_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
            plot_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            crit_q  <= crit_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            col_q   <= col_d;
            mask_q  <= mask_d;
            clr_x_q <= clr_x_d;
            clr_y_q <= clr_y_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            plot_q  <= plot_d;
            done_q  <= done_d;
        end
    end

    assign done           = done_q;
    assign vga.vga_x      = x_q;
    assign vga.vga_y      = y_q;
    assign vga.vga_colour = c_q;
    assign vga.vga_plot   = plot_q;
endmodule

// File: doc/arc_plotter.md
# arc_plotter

Parametrised midpoint-circle arc engine for the VGA drawing pipeline. It is the generalised successor of the fixed 160x120 circle and Reuleaux drawers. Screen size and coordinate/colour widths are parameters. An 8-bit octant mask selects which arc segments are drawn, so Reuleaux, semicircle and full-circle shapes are composed by the caller. Off-screen points are clipped, an optional pre-clear sweep is built in, and a `vga_ready` backpressure handshake lets it share the VGA adapter with other drawers.

## Interface
- `SCREEN_W`, 160: visible columns.
- `SCREEN_H`, 120: visible rows.
- `XW`, 8: x coordinate and radius width; must satisfy 2^XW >= SCREEN_W.
- `YW`, 7: y coordinate width; must satisfy 2^YW >= SCREEN_H.
- `CW`, 3: colour width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; level-held by the caller until `done`.
- `done`  out  1  operation complete; held until `start` falls.
- `centre_x`  in  XW  arc centre x; latched at accept.
- `centre_y`  in  YW  arc centre y; latched at accept.
- `radius`  in  XW  arc radius; latched at accept.
- `colour`  in  CW  arc colour; latched at accept.
- `octant_mask`  in  8  bit i enables octant i; latched at accept.
- `clear_first`  in  1  1 = blank the screen to colour 0 before drawing; latched at accept.
- `vga_x`  out  XW  pixel x.
- `vga_y`  out  YW  pixel y.
- `vga_colour`  out  CW  pixel colour.
- `vga_plot`  out  1  pixel valid.
- `vga_ready`  in  1  sink accepts the pixel this cycle.

## Operation
- States: IDLE, CLEAR, INIT, PLOT, DONE.
- IDLE:
  - `start`=1 latches all inputs.
  - Next state is CLEAR if `clear_first`=1, otherwise INIT.
- CLEAR:
  - Column-major sweep with x outer, y inner, from (0,0) to (SCREEN_W-1, SCREEN_H-1), colour 0.
  - Advances only on acceptance (`vga_plot`&`vga_ready`).
  - The final accept goes to INIT.
- INIT (1 cycle, `vga_plot`=0): ox=radius, oy=0, crit=1-radius.
- PLOT:
  - Eight slots s=0..7 per iteration, one slot per cycle, in this order:
    - s0 (cx+ox, cy+oy)
    - s1 (cx+oy, cy+ox)
    - s2 (cx-oy, cy+ox)
    - s3 (cx-ox, cy+oy)
    - s4 (cx-ox, cy-oy)
    - s5 (cx-oy, cy-ox)
    - s6 (cx+oy, cy-ox)
    - s7 (cx+ox, cy-oy)
  - A slot is live when `octant_mask[s]`=1 and 0<=x<SCREEN_W and 0<=y<SCREEN_H.
  - Live slot: `vga_plot`=1, held with stable x/y/colour until accepted.
  - Dead slot: `vga_plot`=0, consumes exactly 1 cycle regardless of `vga_ready`.
  - Iteration update on leaving s7:
    - oy+=1.
    - If crit<=0: crit+=2*oy+1.
    - Else: ox-=1, then crit+=2*(oy-ox)+1.
    - Values on the right-hand side are post-increment/decrement.
  - Exit: after the update, if oy>ox go to DONE, else go to s0.
- Arithmetic:
  - Coordinates are computed signed at max(XW,YW)+2 bits; no wraparound into the visible range.
  - crit is signed at XW+3 bits.
- Duplicate pixels at octant boundaries are emitted; no deduplication.
- DONE:
  - `done`=1, `vga_plot`=0.
  - `start`=0 returns to IDLE with `done`=0 on the next edge.
- Radius 0: exactly one iteration; every live slot plots the centre.

## Timing
- Reset values (the edge after `rst`=1): state IDLE, `done`=0, `vga_plot`=0, `vga_x`=0, `vga_y`=0, `vga_colour`=0.
- `rst` has priority over everything and aborts mid-CLEAR or mid-PLOT; the pending pixel is dropped.
- Start latency:
  - `start` sampled in IDLE at edge k gives CLEAR or INIT at k+1.
  - If INIT, the first PLOT slot is at k+2.
- Draw length with `vga_ready`=1: 8·N cycles, N = iterations; each stall adds 1 cycle.
- CLEAR length with `vga_ready`=1: SCREEN_W·SCREEN_H cycles.
- `done` rises the edge after the last slot. Input changes after accept are ignored.
- `vga_*` outputs are registered.

## Test plan
- Radius 0, centre (10,40), mask 0xFF, ready=1, clear_first=0 -> eight plots of (10,40); `done` 10 cycles after start is sampled.
- Radius 3, centre (80,60), mask 0x01 -> plots exactly (83,60), (83,61), (82,62); 24 PLOT cycles; `done` then held until `start`=0.
- Centre (2,2), radius 5, mask 0xFF -> no plot with x≥160 or y≥120; slots at negative coordinates (e.g. s4 at (-3,2)) show `vga_plot`=0 and take 1 cycle each.
- Radius 70, centre (80,60), random `vga_ready` -> outputs stable while stalled; pixel sequence identical to the ready=1 run.
- clear_first=1, ready=1:
  - 19200 colour-0 plots: first (0,0), then (0,1), last (159,119).
  - The arc starts 2 cycles later (INIT, then first slot).
- `rst` pulsed mid-PLOT -> next cycle `vga_plot`=0, `done`=0; a fresh start redraws from s0 with new inputs.
